// File: rtl/disk_lsa_calc_pkg.sv
// Shared types and constants for the CHS-to-LSA calculator: FSM states,
// err bit positions and reference drive geometries.
package disk_lsa_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        MUL1   = 3'd2,
        MUL2   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int ERR_CYL = 2;
    localparam int ERR_TRK = 1;
    localparam int ERR_SEC = 0;

    localparam int RP06_NCYL = 815;
    localparam int RP06_NTRK = 19;
    localparam int RP06_NSEC = 22;

    localparam int RP07_NCYL = 630;
    localparam int RP07_NTRK = 32;
    localparam int RP07_NSEC = 50;

    localparam int RM03_NCYL = 823;
    localparam int RM03_NTRK = 5;
    localparam int RM03_NSEC = 32;

endpackage

// File: rtl/disk_lsa_calc_mul.sv
// Iterative LSB-first unsigned shift-add multiplier. One partial product per
// step; sum_next exposes the step result so the caller can chain a new load.
module lsa_shift_add_mul #(
    parameter int ACC_W = 21,
    parameter int MPL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_mcand,
    input  logic [MPL_W-1:0] load_mplier,
    input  logic             step,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] sum_next
);

    logic [ACC_W-1:0] mcand;
    logic [MPL_W-1:0] mplier;

    // addend is only non-zero on a final step, folding the "+ta" into it
    assign sum_next = acc + (mplier[0] ? mcand : '0) + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= load_mcand;
            mplier <= load_mplier;
        end else if (step) begin
            acc    <= sum_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/disk_lsa_calc.sv
// CHS to linear sector address: LSA = ((cyl*ntrk + trk)*nsec + sec) << SCALE_SH,
// with range check. Optional partition offset port under `DISK_LSA_BASE_EN.
module disk_lsa_calc
    import disk_lsa_pkg::*;
#(
    parameter int CYL_W    = 10,
    parameter int TRK_W    = 6,
    parameter int SEC_W    = 6,
    parameter int LSA_W    = 21,
    parameter int SCALE_SH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CYL_W-1:0] ncyl,
    input  logic [TRK_W-1:0] ntrk,
    input  logic [SEC_W-1:0] nsec,
    input  logic [CYL_W-1:0] dca,
    input  logic [TRK_W-1:0] ta,
    input  logic [SEC_W-1:0] sa,
`ifdef DISK_LSA_BASE_EN
    input  logic [LSA_W-1:0] base,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err,
    output logic [LSA_W-1:0] lsa
);

    localparam int MPL_W = (TRK_W > SEC_W) ? TRK_W : SEC_W;
    localparam int CNT_W = $clog2(MPL_W + 1);

    state_t state, state_next;

    logic [CYL_W-1:0] ncyl_q, dca_q;
    logic [TRK_W-1:0] ntrk_q, ta_q;
    logic [SEC_W-1:0] nsec_q, sa_q;
`ifdef DISK_LSA_BASE_EN
    logic [LSA_W-1:0] base_q;
`endif
    logic [CNT_W-1:0] cnt;
    logic [2:0]       err_chk;
    logic             mul1_last, mul2_last;
    logic [LSA_W-1:0] finish_lsa;

    logic             mul_load, mul_step;
    logic [LSA_W-1:0] mul_mcand, mul_addend, acc, sum_next;
    logic [MPL_W-1:0] mul_mplier;

    lsa_shift_add_mul #(
        .ACC_W (LSA_W),
        .MPL_W (MPL_W)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .load        (mul_load),
        .load_mcand  (mul_mcand),
        .load_mplier (mul_mplier),
        .step        (mul_step),
        .addend      (mul_addend),
        .acc         (acc),
        .sum_next    (sum_next)
    );

    assign busy      = (state != IDLE);
    assign mul1_last = (cnt == CNT_W'(TRK_W - 1));
    assign mul2_last = (cnt == CNT_W'(SEC_W - 1));

    // Zero counts fall out naturally: any address is >= 0
    always_comb begin
        err_chk          = '0;
        err_chk[ERR_CYL] = (dca_q >= ncyl_q);
        err_chk[ERR_TRK] = (ta_q >= ntrk_q);
        err_chk[ERR_SEC] = (sa_q >= nsec_q);
    end

`ifdef DISK_LSA_BASE_EN
    assign finish_lsa = ((acc + LSA_W'(sa_q)) << SCALE_SH) + base_q;
`else
    assign finish_lsa = (acc + LSA_W'(sa_q)) << SCALE_SH;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The last MUL1 step reloads the multiplier with dca*ntrk+ta as the new
    // multiplicand, so MUL2 starts without a bubble cycle.
    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        mul_mcand  = '0;
        mul_mplier = '0;
        mul_addend = '0;
        case (state)
            IDLE: begin
                if (start) state_next = CHECK;
            end
            CHECK: begin
                if (|err_chk) begin
                    state_next = IDLE;
                end else begin
                    mul_load   = 1'b1;
                    mul_mcand  = LSA_W'(dca_q);
                    mul_mplier = MPL_W'(ntrk_q);
                    state_next = MUL1;
                end
            end
            MUL1: begin
                if (mul1_last) begin
                    mul_addend = LSA_W'(ta_q);
                    mul_load   = 1'b1;
                    mul_mcand  = sum_next;
                    mul_mplier = MPL_W'(nsec_q);
                    state_next = MUL2;
                end else begin
                    mul_step = 1'b1;
                end
            end
            MUL2: begin
                mul_step = 1'b1;
                if (mul2_last) state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncyl_q <= '0;
            ntrk_q <= '0;
            nsec_q <= '0;
            dca_q  <= '0;
            ta_q   <= '0;
            sa_q   <= '0;
`ifdef DISK_LSA_BASE_EN
            base_q <= '0;
`endif
            cnt    <= '0;
            err    <= '0;
            lsa    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ncyl_q <= ncyl;
                        ntrk_q <= ntrk;
                        nsec_q <= nsec;
                        dca_q  <= dca;
                        ta_q   <= ta;
                        sa_q   <= sa;
`ifdef DISK_LSA_BASE_EN
                        base_q <= base;
`endif
                        err    <= '0;
                    end
                end
                CHECK: begin
                    err <= err_chk;
                    cnt <= '0;
                    if (|err_chk) begin
                        lsa  <= '0;
                        done <= 1'b1;
                    end
                end
                MUL1: begin
                    cnt <= mul1_last ? '0 : cnt + 1'b1;
                end
                MUL2: begin
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    lsa  <= finish_lsa;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_disk_lsa_calc.sv
// Directed bench for disk_lsa_calc: driver pushes hand-computed results into a
// queue, a negedge monitor pops and compares on every done pulse.
module tb_disk_lsa_calc;
    import disk_lsa_pkg::*;

    localparam int CYL_W = 10;
    localparam int TRK_W = 6;
    localparam int SEC_W = 6;
    localparam int LSA_W = 21;
    localparam int W     = 3 + LSA_W;
    localparam int LAT   = 15;
    localparam int LAT_E = 2;
`ifdef DISK_LSA_BASE_EN
    localparam logic [LSA_W-1:0] BASE_ADD = 21'h10000;
`else
    localparam logic [LSA_W-1:0] BASE_ADD = '0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CYL_W-1:0] ncyl = '0, dca = '0;
    logic [TRK_W-1:0] ntrk = '0, ta = '0;
    logic [SEC_W-1:0] nsec = '0, sa = '0;
    logic [LSA_W-1:0] base = BASE_ADD;
    logic             start = 1'b0;
    logic             busy, done;
    logic [2:0]       err;
    logic [LSA_W-1:0] lsa;

    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    int           bcnt;

    disk_lsa_calc #(
        .CYL_W (CYL_W), .TRK_W (TRK_W), .SEC_W (SEC_W), .LSA_W (LSA_W), .SCALE_SH (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ncyl  (ncyl),
        .ntrk  (ntrk),
        .nsec  (nsec),
        .dca   (dca),
        .ta    (ta),
        .sa    (sa),
`ifdef DISK_LSA_BASE_EN
        .base  (base),
`endif
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .lsa   (lsa)
    );

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [W-1:0] e;
                int           c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("lsa", lsa, e[LSA_W-1:0]);
                chk("err", err, e[W-1:LSA_W]);
                chk("done_cycle", cyc, c);
            end
        end
    end

    // driver: called at a negedge; returns at the negedge after the start cycle
    task automatic issue(input int g_cyl, input int g_trk, input int g_sec,
                         input int d, input int t, input int s,
                         input logic [LSA_W-1:0] e_lsa, input logic [2:0] e_err,
                         input int lat);
        ncyl  = CYL_W'(g_cyl);
        ntrk  = TRK_W'(g_trk);
        nsec  = SEC_W'(g_sec);
        dca   = CYL_W'(d);
        ta    = TRK_W'(t);
        sa    = SEC_W'(s);
        start = 1'b1;
        exp_q.push_back({e_err, e_lsa});
        cyc_q.push_back(cyc + lat);
        @(negedge clk);
        start = 1'b0;
        ncyl  = CYL_W'($urandom);
        ntrk  = TRK_W'($urandom);
        nsec  = SEC_W'($urandom);
        dca   = CYL_W'($urandom);
        ta    = TRK_W'($urandom);
        sa    = SEC_W'($urandom);
        base  = LSA_W'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) return;
            if (busy) busy_cycles = busy_cycles + 1;
            @(negedge clk);
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lsa", lsa, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // RP06 origin
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 0, 0, 0, 21'd0 + BASE_ADD, 3'b000, LAT);
        wait_done(bcnt);
        @(negedge clk);

        // RP06 1/2/3 -> 930, busy for CHECK+MUL1+MUL2+FINISH
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 1, 2, 3, 21'd930 + BASE_ADD, 3'b000, LAT);
        wait_done(bcnt);
        chk("busy_cycles", bcnt, 14);
        chk("busy_low_at_done", busy, 0);
        @(negedge clk);

        // RP06 last sector
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 814, 18, 21, 21'd681338 + BASE_ADD, 3'b000, LAT);
        wait_done(bcnt);
        @(negedge clk);

        // range errors
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 814, 18, 22, 21'd0, 3'b001, LAT_E);
        wait_done(bcnt);
        @(negedge clk);
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 815, 19, 21, 21'd0, 3'b110, LAT_E);
        wait_done(bcnt);
        @(negedge clk);
        issue(RP06_NCYL, 0, RP06_NSEC, 0, 0, 0, 21'd0, 3'b010, LAT_E);
        wait_done(bcnt);
        @(negedge clk);

        // RP07 and RM03 last sectors, issued back-to-back in the done cycle
        base = BASE_ADD;
        issue(RP07_NCYL, RP07_NTRK, RP07_NSEC, 629, 31, 49, 21'd2015998 + BASE_ADD, 3'b000, LAT);
        wait_done(bcnt);
        base = BASE_ADD;
        issue(RM03_NCYL, RM03_NTRK, RM03_NSEC, 822, 4, 31, 21'd263358 + BASE_ADD, 3'b000, LAT);
        chk("busy_after_done_start", busy, 1);
        wait_done(bcnt);
        @(negedge clk);

        // start while busy is ignored
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 1, 2, 3, 21'd930 + BASE_ADD, 3'b000, LAT);
        repeat (4) @(negedge clk);
        ncyl = CYL_W'(RP06_NCYL); ntrk = TRK_W'(RP06_NTRK); nsec = SEC_W'(RP06_NSEC);
        dca = 10'd814; ta = 6'd18; sa = 6'd21;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bcnt);
        repeat (20) @(negedge clk);

        // reset mid-calculation
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 814, 18, 21, 21'd681338 + BASE_ADD, 3'b000, LAT);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lsa", lsa, 0);
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = BASE_ADD;
        issue(RP06_NCYL, RP06_NTRK, RP06_NSEC, 1, 2, 3, 21'd930 + BASE_ADD, 3'b000, LAT);
        wait_done(bcnt);

        repeat (30) @(negedge clk);
        chk("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
